cntr_3ud_mon: RTL and testbench
===============================

# cntr_3ud_mon

Registered step monitor that sits directly downstream of the 3-bit up/down counter `cntr_3ud` and consumes its `bin_count` output together with the `up_down` control and the counter's own reset. Every cycle it computes the value the counter must produce next, flags any illegal step, and reports wrap-around and direction-change events. It gives the counter and its drivers an in-design self-check, with sticky error status and a saturating error count for software or a bench to read.

## Interface
- `WIDTH`, 3: counter width; must match `cntr_3ud`.
- `ECW`, 8: error-counter width.

- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low; `reset == 0` at a rising edge resets the block.
- `cntr_rst`  in  1  the counter's active-high reset, tapped from the counter's input.
- `up_down`  in  1  counter direction as presented to the counter; 1 = decrement, 0 = increment.
- `bin_count`  in  WIDTH  counter output.
- `clr_err`  in  1  synchronous clear of `err_sticky` and `err_cnt`.
- `exp_count`  out  WIDTH  expected `bin_count` for the current cycle.
- `step_err`  out  1  one-cycle pulse on a mismatch.
- `err_sticky`  out  1  set on any mismatch; held until `clr_err` or reset.
- `err_cnt`  out  ECW  number of mismatches; saturates at 2^ECW-1.
- `wrap_up`  out  1  pulse on an observed legal increment from 7 to 0.
- `wrap_dn`  out  1  pulse on an observed legal decrement from 0 to 7.
- `dir_chg`  out  1  pulse when `up_down` differs from its value on the previous sample.

## Operation
- Each edge, the block registers `prev_cnt <= bin_count`, `prev_ud <= up_down` and `prev_rst <= cntr_rst`.
- Expected value:
  - `exp = 0` if `prev_rst`.
  - Otherwise `exp = prev_cnt - 1` if `prev_ud`.
  - Otherwise `exp = prev_cnt + 1`.
  - Arithmetic is modulo 2^WIDTH.
  - `exp_count` is driven from the registered `exp`.
- FSM states: INIT, TRACK, FAIL.
  - INIT: no check. Captures the first sample and moves to TRACK on the next edge.
  - TRACK: checks `bin_count == exp`. On a mismatch, moves to FAIL.
  - FAIL: checking continues as in TRACK. `clr_err` with no new mismatch returns to TRACK.
- On a mismatch:
  - `step_err` pulses.
  - `err_sticky` is set to 1.
  - `err_cnt` increments, saturating at all-ones (255 at the default width).
- `wrap_up` / `wrap_dn` fire only on a matching check with `prev_rst == 0`:
  - `wrap_up`: `prev_cnt == 7`, `prev_ud == 0`, `bin_count == 0`.
  - `wrap_dn`: `prev_cnt == 0`, `prev_ud == 1`, `bin_count == 7`.
- `dir_chg` is suppressed in INIT.
- Simultaneous `clr_err` and a mismatch: the mismatch wins. Result is `err_sticky = 1`, `err_cnt = 1`, state FAIL.
- `cntr_rst` held high: every check expects 0. A non-zero `bin_count` is an error.
- `reset` asserted mid-operation: the next edge forces INIT and clears all outputs. The following cycle is a capture-only cycle.

## Timing
- Outputs after reset:
  - `exp_count = 0`, `step_err = 0`, `err_sticky = 0`, `err_cnt = 0`.
  - `wrap_up = 0`, `wrap_dn = 0`, `dir_chg = 0`.
  - State INIT.
- Latency: a bad `bin_count` present before edge n produces `step_err` high during the cycle after edge n.
  - The same one-cycle registered latency applies to `wrap_*` and `dir_chg`.
- The first check happens at the second edge after `reset` deasserts.
- All pulses are exactly one cycle wide. Back-to-back events produce back-to-back pulses.
- No combinational path from inputs to outputs.

## Structure
- Shared package `cntr_3ud_pkg` holds:
  - `CNT_W = 3`.
  - `typedef enum logic [1:0] {MON_INIT, MON_TRACK, MON_FAIL} mon_state_t`.
  - Function `cntr_next(cnt, up_down, rst)`, reused by the bench model.
- One sub-module, `sat_cntr`: a parameterised saturating counter with `inc` and `clr` inputs, where `inc` has priority. It implements `err_cnt`.

## Test plan
- `reset = 0` for 2 edges with random inputs -> all outputs 0, state INIT. No `step_err` on the first edge after release.
- `cntr_rst` 1 then 0, `up_down = 0`, counter runs 0..7,0,1 -> no `step_err`. Exactly one `wrap_up`, one cycle after `bin_count` shows 0.
- `up_down = 1` from 0 -> 7,6 -> one `wrap_dn`. Toggling `up_down` 0→1 -> one `dir_chg` pulse.
- Force `bin_count` 3→5 with `up_down = 0` -> `step_err` for 1 cycle, `err_sticky = 1`, `err_cnt = 1`, state FAIL. `clr_err` -> sticky 0, count 0, state TRACK.
- 300 consecutive forced mismatches -> `err_cnt` stops at 255, `step_err` high for all 300 cycles.
- `clr_err` on the same edge as a mismatch -> `err_cnt = 1`, `err_sticky = 1`. `reset` asserted mid-count -> INIT, then the first check resumes 2 edges after release.

Source files
------------

// File: rtl/cntr_3ud_pkg.sv
// Shared types and helpers for the 3-bit up/down counter and its step monitor.
package cntr_3ud_pkg;

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    MON_INIT,
    MON_TRACK,
    MON_FAIL
  } mon_state_t;

  // Value the counter must present one edge after showing cnt with the given controls.
  function automatic logic [CNT_W-1:0] cntr_next(input logic [CNT_W-1:0] cnt,
                                                 input logic             up_down,
                                                 input logic             rst);
    logic [CNT_W-1:0] nxt;
    if (rst) begin
      nxt = '0;
    end else if (up_down) begin
      nxt = cnt - CNT_W'(1);
    end else begin
      nxt = cnt + CNT_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sat_cntr.sv
// Saturating event counter; an increment on the same edge as a clear leaves a count of one.
module sat_cntr #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  // Next count: clear restarts from the current event, otherwise climb until all-ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = inc ? W'(1) : '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cntr_3ud_mon.sv
// Registered step monitor for cntr_3ud: predicts each counter value, flags illegal steps,
// and reports wrap-around and direction-change events one cycle after they are observed.
module cntr_3ud_mon
  import cntr_3ud_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W, // must equal CNT_W; the prediction uses cntr_next
  parameter int unsigned ECW   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cntr_rst,
  input  logic             up_down,
  input  logic [WIDTH-1:0] bin_count,
  input  logic             clr_err,
  output logic [WIDTH-1:0] exp_count,
  output logic             step_err,
  output logic             err_sticky,
  output logic [ECW-1:0]   err_cnt,
  output logic             wrap_up,
  output logic             wrap_dn,
  output logic             dir_chg
);

  localparam logic [WIDTH-1:0] CntMax = '1;

  mon_state_t       state_q;
  logic [WIDTH-1:0] prev_cnt_q;
  logic             prev_ud_q;
  logic             prev_rst_q;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             step_err_q, err_sticky_q;
  logic             wrap_up_q, wrap_dn_q, dir_chg_q;
  logic             checking;
  logic             mismatch;

  // exp_q already holds the prediction made from the previous sample, so it is the target
  // for this edge's check.
  assign exp_d    = WIDTH'(cntr_next(CNT_W'(bin_count), up_down, cntr_rst));
  assign checking = (state_q != MON_INIT);
  assign mismatch = checking && (bin_count != exp_q);

  // Sample history, prediction, status flags and the monitor FSM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= MON_INIT;
      prev_cnt_q   <= '0;
      prev_ud_q    <= 1'b0;
      prev_rst_q   <= 1'b0;
      exp_q        <= '0;
      step_err_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      wrap_up_q    <= 1'b0;
      wrap_dn_q    <= 1'b0;
      dir_chg_q    <= 1'b0;
    end else begin
      prev_cnt_q <= bin_count;
      prev_ud_q  <= up_down;
      prev_rst_q <= cntr_rst;
      exp_q      <= exp_d;
      step_err_q <= mismatch;

      // A fresh mismatch outranks a clear request.
      if (mismatch) begin
        err_sticky_q <= 1'b1;
      end else if (clr_err) begin
        err_sticky_q <= 1'b0;
      end

      wrap_up_q <= checking && !mismatch && !prev_rst_q && !prev_ud_q &&
                   (prev_cnt_q == CntMax) && (bin_count == '0);
      wrap_dn_q <= checking && !mismatch && !prev_rst_q && prev_ud_q &&
                   (prev_cnt_q == '0) && (bin_count == CntMax);
      dir_chg_q <= checking && (up_down != prev_ud_q);

      unique case (state_q)
        MON_INIT:  state_q <= MON_TRACK;
        MON_TRACK: if (mismatch) state_q <= MON_FAIL;
        MON_FAIL:  if (!mismatch && clr_err) state_q <= MON_TRACK;
        default:   state_q <= MON_INIT;
      endcase
    end
  end

  sat_cntr #(
    .W (ECW)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (mismatch),
    .clr   (clr_err),
    .count (err_cnt)
  );

  assign exp_count  = exp_q;
  assign step_err   = step_err_q;
  assign err_sticky = err_sticky_q;
  assign wrap_up    = wrap_up_q;
  assign wrap_dn    = wrap_dn_q;
  assign dir_chg    = dir_chg_q;

endmodule

// File: tb/tb_cntr_3ud_mon.sv
// Self-checking bench for cntr_3ud_mon: hand-computed vector table, directed corner
// sequences, and randomized traffic checked against a behavioural model.
module tb_cntr_3ud_mon;

  logic       clk = 1'b0;
  logic       reset, cntr_rst, up_down, clr_err;
  logic [2:0] bin_count;
  logic [2:0] exp_count;
  logic       step_err, err_sticky, wrap_up, wrap_dn, dir_chg;
  logic [7:0] err_cnt;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model state (0 = capture phase, 1 = tracking, 2 = failed).
  int m_state = 0;
  int m_exp   = 0;
  int m_cnt   = 0;
  int m_prev_cnt = 0, m_prev_ud = 0, m_prev_rst = 0;
  bit m_step = 0, m_sticky = 0, m_wu = 0, m_wd = 0, m_dc = 0;

  typedef struct {
    int rst_n, crst, ud, cnt, clr;
    int e_step, e_wu, e_wd, e_dc, e_sticky, e_ecnt, e_exp;
  } vec_t;

  vec_t vecs[20];

  always #5 clk = ~clk;

  cntr_3ud_mon #(
    .WIDTH (3),
    .ECW   (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cntr_rst   (cntr_rst),
    .up_down    (up_down),
    .bin_count  (bin_count),
    .clr_err    (clr_err),
    .exp_count  (exp_count),
    .step_err   (step_err),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt),
    .wrap_up    (wrap_up),
    .wrap_dn    (wrap_dn),
    .dir_chg    (dir_chg)
  );

  function automatic int ref_next(input int c, input int u, input int r);
    if (r != 0) return 0;
    return (u != 0) ? (c + 7) % 8 : (c + 1) % 8;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Advance the model by one rising edge using the currently driven inputs.
  task automatic model_edge();
    bit mm;
    if (!reset) begin
      m_state = 0; m_exp = 0; m_cnt = 0;
      m_step = 0; m_sticky = 0; m_wu = 0; m_wd = 0; m_dc = 0;
    end else begin
      if (m_state == 0) begin
        m_step = 0; m_wu = 0; m_wd = 0; m_dc = 0;
        if (clr_err) begin m_sticky = 0; m_cnt = 0; end
        m_state = 1;
      end else begin
        mm     = (int'(bin_count) != m_exp);
        m_step = mm;
        m_wu   = !mm && m_prev_rst == 0 && m_prev_ud == 0 && m_prev_cnt == 7 && bin_count == 0;
        m_wd   = !mm && m_prev_rst == 0 && m_prev_ud == 1 && m_prev_cnt == 0 && bin_count == 7;
        m_dc   = (int'(up_down) != m_prev_ud);
        if (mm) begin
          m_sticky = 1;
          m_cnt    = clr_err ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
          m_state  = 2;
        end else if (clr_err) begin
          m_sticky = 0;
          m_cnt    = 0;
          if (m_state == 2) m_state = 1;
        end
      end
      m_exp = ref_next(int'(bin_count), int'(up_down), int'(cntr_rst));
    end
    m_prev_cnt = int'(bin_count);
    m_prev_ud  = int'(up_down);
    m_prev_rst = int'(cntr_rst);
  endtask

  task automatic compare_all(input string tag);
    chk({tag, " exp_count"},  int'(exp_count),   m_exp);
    chk({tag, " step_err"},   int'(step_err),    int'(m_step));
    chk({tag, " err_sticky"}, int'(err_sticky),  int'(m_sticky));
    chk({tag, " err_cnt"},    int'(err_cnt),     m_cnt);
    chk({tag, " wrap_up"},    int'(wrap_up),     int'(m_wu));
    chk({tag, " wrap_dn"},    int'(wrap_dn),     int'(m_wd));
    chk({tag, " dir_chg"},    int'(dir_chg),     int'(m_dc));
    chk({tag, " state"},      int'(dut.state_q), m_state);
  endtask

  // Drive one cycle of inputs, clock it, then compare 1 time unit after the edge.
  task automatic step(input string tag, input logic r, input logic c, input logic u,
                      input logic [2:0] b, input logic cl);
    reset = r; cntr_rst = c; up_down = u; bin_count = b; clr_err = cl;
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  initial begin
    int n_wu, n_err;
    int last_cnt, last_ud, last_rst;
    logic r, c, u, cl;
    logic [2:0] b;

    reset = 1'b0; cntr_rst = 1'b0; up_down = 1'b0; bin_count = '0; clr_err = 1'b0;

    // rst_n crst ud cnt clr | step wu wd dc sticky ecnt exp
    vecs[0]  = '{0, 0, 0, 5, 0,  0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 1, 2, 1,  0, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{1, 1, 0, 3, 0,  0, 0, 0, 0, 0, 0, 0};
    vecs[3]  = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1};
    vecs[4]  = '{1, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 2};
    vecs[5]  = '{1, 0, 0, 2, 0,  0, 0, 0, 0, 0, 0, 3};
    vecs[6]  = '{1, 0, 0, 3, 0,  0, 0, 0, 0, 0, 0, 4};
    vecs[7]  = '{1, 0, 0, 5, 0,  1, 0, 0, 0, 1, 1, 6};
    vecs[8]  = '{1, 0, 0, 6, 1,  0, 0, 0, 0, 0, 0, 7};
    vecs[9]  = '{1, 0, 0, 7, 0,  0, 0, 0, 0, 0, 0, 0};
    vecs[10] = '{1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 1};
    vecs[11] = '{1, 0, 1, 1, 0,  0, 0, 0, 1, 0, 0, 0};
    vecs[12] = '{1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 7};
    vecs[13] = '{1, 0, 1, 7, 0,  0, 0, 1, 0, 0, 0, 6};
    vecs[14] = '{1, 0, 1, 2, 0,  1, 0, 0, 0, 1, 1, 1};
    vecs[15] = '{1, 0, 1, 5, 1,  1, 0, 0, 0, 1, 1, 4};
    vecs[16] = '{1, 0, 1, 4, 0,  0, 0, 0, 0, 1, 1, 3};
    vecs[17] = '{0, 0, 1, 4, 0,  0, 0, 0, 0, 0, 0, 0};
    vecs[18] = '{1, 0, 0, 4, 0,  0, 0, 0, 0, 0, 0, 5};
    vecs[19] = '{1, 0, 0, 6, 0,  1, 0, 0, 0, 1, 1, 7};

    for (int i = 0; i < 20; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      step(t, vecs[i].rst_n[0], vecs[i].crst[0], vecs[i].ud[0], vecs[i].cnt[2:0],
           vecs[i].clr[0]);
      chk({t, " tbl step_err"},   int'(step_err),   vecs[i].e_step);
      chk({t, " tbl wrap_up"},    int'(wrap_up),    vecs[i].e_wu);
      chk({t, " tbl wrap_dn"},    int'(wrap_dn),    vecs[i].e_wd);
      chk({t, " tbl dir_chg"},    int'(dir_chg),    vecs[i].e_dc);
      chk({t, " tbl err_sticky"}, int'(err_sticky), vecs[i].e_sticky);
      chk({t, " tbl err_cnt"},    int'(err_cnt),    vecs[i].e_ecnt);
      chk({t, " tbl exp_count"},  int'(exp_count),  vecs[i].e_exp);
    end

    // Counter reset, then a clean 0..7,0,1 run: one wrap_up and no errors.
    step("wrapA setup", 1'b1, 1'b1, 1'b0, 3'd4, 1'b1);
    n_wu = 0; n_err = 0;
    for (int i = 0; i < 10; i++) begin
      logic [2:0] v;
      v = 3'(i % 8);
      step($sformatf("wrapA%0d", i), 1'b1, 1'b0, 1'b0, v, 1'b0);
      if (wrap_up) n_wu++;
      if (step_err) n_err++;
    end
    chk("wrapA wrap_up pulses", n_wu, 1);
    chk("wrapA step_err pulses", n_err, 0);

    // 300 back-to-back mismatches: err_cnt saturates, step_err never drops.
    step("sat setup0", 1'b1, 1'b1, 1'b0, 3'd2, 1'b1);
    step("sat setup1", 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
    chk("sat setup err_cnt", int'(err_cnt), 0);
    n_err = 0;
    for (int i = 0; i < 300; i++) begin
      step($sformatf("sat%0d", i), 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
      if (step_err) n_err++;
    end
    chk("sat step_err cycles", n_err, 300);
    chk("sat err_cnt final", int'(err_cnt), 255);
    chk("sat err_sticky", int'(err_sticky), 1);

    // Randomized traffic: mostly legal counter steps with occasional faults and resets.
    last_cnt = 0; last_ud = 0; last_rst = 1;
    for (int i = 0; i < 2000; i++) begin
      r  = ($urandom_range(0, 99) >= 2);
      c  = ($urandom_range(0, 99) < 5);
      u  = ($urandom_range(0, 99) < 20) ? ~1'(last_ud) : 1'(last_ud);
      cl = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 8) b = 3'($urandom_range(0, 7));
      else b = 3'(ref_next(last_cnt, last_ud, last_rst));
      step($sformatf("rnd%0d", i), r, c, u, b, cl);
      last_cnt = int'(b); last_ud = int'(u); last_rst = int'(c);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
